i2c_cmd_ctrl: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_sync_fifo.sv | 84 ++++++++
 rtl/i2c_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_cmd_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command controller.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - read/write direction encoding
//   - default SCL divider value
//   - command-length legality helper
package i2c_pkg;

    localparam logic [2:0] ST_RST_WAIT = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_XFER     = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [15:0] DEFAULT_DIVIDER = 16'd124;

    // A command length is usable only if it is non-zero and fits in one FIFO.
    function automatic logic len_is_legal(input logic [7:0] len, input int depth);
        return (len != 8'd0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (pointers only)
//   i_push, i_data        write side; push when full is ignored unless popping
//   i_pop                 pop the head (ignored when empty)
//   i_drop, i_drop_cnt    discard up to i_drop_cnt entries from the head
//   o_data                current head
//   o_peek                entry behind the head
//   o_full, o_empty       status
//   o_count               occupancy
module i2c_sync_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    input  logic                  i_drop,
    input  logic [PTR_W-1:0]      i_drop_cnt,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_peek,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [PTR_W-1:0]      o_count
);

    localparam int AW = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [AW-1:0]    IDX_ONE = AW'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         rd_idx_p1;
    logic [PTR_W-1:0]      drop_n;
    logic                  do_push;
    logic                  do_pop;

    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rd_idx_p1 = rd_idx + IDX_ONE;

    assign o_count = wr_ptr - rd_ptr;
    assign o_full  = (o_count == PTR_W'(FIFO_DEPTH));
    assign o_empty = (o_count == '0);

    assign do_pop  = i_pop && !o_empty;
    // When full, a push is only taken if the head leaves in the same cycle.
    assign do_push = i_push && (!o_full || do_pop);
    assign drop_n  = (i_drop_cnt > o_count) ? o_count : i_drop_cnt;

    assign o_data = mem[rd_idx];
    assign o_peek = mem[rd_idx_p1];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_idx] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end else if (i_drop) begin
                rd_ptr <= rd_ptr + drop_n;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_ctrl.sv
// Command-level front end for the byte-level I2C master.
// Accepts one command (rw, addr, len), feeds write bytes from the TX FIFO to
// the master, collects read bytes into the RX FIFO, and reports completion.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_cfg_divider                   SCL divider, passed straight to o_m_divider
//   i_cmd_* / o_cmd_ready           command handshake
//   i_wr_* / o_wr_ready             TX FIFO push side
//   o_rd_* / i_rd_ready             RX FIFO pop side
//   o_done, o_err                   end-of-command pulse and status
//   o_m_*                           inputs of the byte-level master
//   i_m_*                           outputs of the byte-level master
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RST_WAIT  | wait for the (unreset) master to be idle for 2 cycles
// IDLE      | ready for a command once resources are available
// ISSUE     | enable raised, waiting for the START en_ack
// XFER      | burst in progress, waiting for busy to fall
// FINISH    | one-cycle done/err report, flush unsent TX bytes on error
module i2c_cmd_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [15:0]           i_cfg_divider,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [7:0]            i_cmd_len,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_rd_ready,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_m_enable,
    output logic                  o_m_rw,
    output logic [DATA_WIDTH-1:0] o_m_mosi_data,
    output logic [ADDR_WIDTH-1:0] o_m_device_addr,
    output logic [7:0]            o_m_num_byte,
    output logic [15:0]           o_m_divider,
    input  logic                  i_m_en_ack,
    input  logic                  i_m_data_valid,
    input  logic [DATA_WIDTH-1:0] i_m_miso_data,
    input  logic                  i_m_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]            state;
    logic                  rst_tmr;
    logic                  busy_q;
    logic                  seen_busy;
    logic                  illegal_q;
    logic                  wr_rdy_q;
    logic [7:0]            sent_cnt;
    logic [7:0]            rcv_cnt;

    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] tx_peek;
    logic                  tx_full;
    logic                  tx_empty;
    logic [PTR_W-1:0]      tx_count;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_drop;
    logic [PTR_W-1:0]      tx_drop_cnt;

    logic [DATA_WIDTH-1:0] rx_peek;
    logic                  rx_full;
    logic                  rx_empty;
    logic [PTR_W-1:0]      rx_count;
    logic                  rx_push;
    logic                  rx_pop;

    logic [8:0]            tx_occ;
    logic [8:0]            rx_free;
    logic                  cmd_legal;
    logic                  cmd_fits;
    logic                  cmd_fire;
    logic                  busy_fall;
    logic                  active;
    logic                  wr_ack;
    logic                  wr_last;
    logic                  fin_err;
    logic                  unused_fifo_status;

    assign o_m_divider = i_cfg_divider;

    assign tx_occ    = 9'(tx_count);
    assign rx_free   = 9'(FIFO_DEPTH) - 9'(rx_count);
    assign cmd_legal = len_is_legal(i_cmd_len, FIFO_DEPTH);
    assign cmd_fits  = (i_cmd_rw == RW_READ) ? (rx_free >= {1'b0, i_cmd_len})
                                             : (tx_occ  >= {1'b0, i_cmd_len});

    // Illegal lengths never touch the bus, so they are taken regardless of busy.
    assign o_cmd_ready = (state == ST_IDLE) && (!cmd_legal || (!i_m_busy && cmd_fits));
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    assign busy_fall = seen_busy && busy_q && !i_m_busy;
    assign active    = (state == ST_ISSUE) || (state == ST_XFER);
    assign wr_ack    = active && (o_m_rw == RW_WRITE) && i_m_en_ack;
    assign wr_last   = ((sent_cnt + 8'd1) == o_m_num_byte);

    assign o_wr_ready = wr_rdy_q && !tx_full;
    assign tx_push    = i_wr_valid && o_wr_ready;
    assign tx_pop     = wr_ack;

    assign rx_push    = (state == ST_XFER) && (o_m_rw == RW_READ) && i_m_data_valid;
    assign o_rd_valid = !rx_empty;
    assign rx_pop     = i_rd_ready && o_rd_valid;

    assign fin_err = illegal_q ||
                     ((o_m_rw == RW_WRITE) ? (sent_cnt != o_m_num_byte)
                                           : (rcv_cnt  != o_m_num_byte));
    assign o_done  = (state == ST_FINISH);
    assign o_err   = o_done && fin_err;

    // Bytes of a failed write that were never consumed must not leak into
    // the next command.
    assign tx_drop     = o_done && !illegal_q && (o_m_rw == RW_WRITE) &&
                         (sent_cnt < o_m_num_byte);
    assign tx_drop_cnt = PTR_W'(o_m_num_byte - sent_cnt);

    assign unused_fifo_status = ^{tx_empty, rx_peek, rx_full};

    i2c_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (tx_push),
        .i_data     (i_wr_data),
        .i_pop      (tx_pop),
        .i_drop     (tx_drop),
        .i_drop_cnt (tx_drop_cnt),
        .o_data     (tx_head),
        .o_peek     (tx_peek),
        .o_full     (tx_full),
        .o_empty    (tx_empty),
        .o_count    (tx_count)
    );

    i2c_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (rx_push),
        .i_data     (i_m_miso_data),
        .i_pop      (rx_pop),
        .i_drop     (1'b0),
        .i_drop_cnt ('0),
        .o_data     (o_rd_data),
        .o_peek     (rx_peek),
        .o_full     (rx_full),
        .o_empty    (rx_empty),
        .o_count    (rx_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_RST_WAIT;
            rst_tmr         <= 1'b1;
            busy_q          <= 1'b0;
            seen_busy       <= 1'b0;
            illegal_q       <= 1'b0;
            wr_rdy_q        <= 1'b0;
            sent_cnt        <= 8'd0;
            rcv_cnt         <= 8'd0;
            o_m_enable      <= 1'b0;
            o_m_rw          <= RW_WRITE;
            o_m_mosi_data   <= '0;
            o_m_device_addr <= '0;
            o_m_num_byte    <= 8'd0;
        end else begin
            busy_q   <= i_m_busy;
            wr_rdy_q <= 1'b1;
            case (state)
                ST_RST_WAIT: begin
                    // Down-counter: needs busy low at terminal count to leave.
                    if (i_m_busy) begin
                        rst_tmr <= 1'b1;
                    end else if (rst_tmr == 1'b0) begin
                        state <= ST_IDLE;
                    end else begin
                        rst_tmr <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (!cmd_legal) begin
                            illegal_q <= 1'b1;
                            state     <= ST_FINISH;
                        end else begin
                            illegal_q       <= 1'b0;
                            o_m_rw          <= i_cmd_rw;
                            o_m_device_addr <= i_cmd_addr;
                            o_m_num_byte    <= i_cmd_len;
                            sent_cnt        <= 8'd0;
                            rcv_cnt         <= 8'd0;
                            seen_busy       <= 1'b0;
                            o_m_enable      <= 1'b1;
                            if (i_cmd_rw == RW_WRITE) begin
                                o_m_mosi_data <= tx_head;
                            end
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (i_m_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (i_m_en_ack) begin
                        state <= ST_XFER;
                        if (o_m_rw == RW_WRITE) begin
                            sent_cnt      <= sent_cnt + 8'd1;
                            o_m_mosi_data <= tx_peek;
                            if (wr_last) begin
                                o_m_enable <= 1'b0;
                            end
                        end else begin
                            o_m_enable <= 1'b0;
                        end
                    end else if (busy_fall) begin
                        o_m_enable <= 1'b0;
                        state      <= ST_FINISH;
                    end
                end
                ST_XFER: begin
                    if (i_m_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (wr_ack) begin
                        sent_cnt      <= sent_cnt + 8'd1;
                        o_m_mosi_data <= tx_peek;
                        if (wr_last) begin
                            o_m_enable <= 1'b0;
                        end
                    end
                    if (rx_push) begin
                        rcv_cnt <= rcv_cnt + 8'd1;
                    end
                    if (busy_fall) begin
                        o_m_enable <= 1'b0;
                        state      <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_RST_WAIT;
                end
            endcase
        end
    end

    // Ready gating reserves RX space before a read starts.
    rx_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                     !(rx_push && rx_full));

endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
module tb_i2c_cmd_ctrl;
    import i2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_divider = DEFAULT_DIVIDER;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        rd_ready = 1'b0;
    logic        m_en_ack = 1'b0;
    logic        m_data_valid = 1'b0;
    logic [7:0]  m_miso = '0;
    logic        m_busy = 1'b0;

    logic        cmd_ready, wr_ready, rd_valid, done, err, m_enable, m_rw;
    logic [7:0]  rd_data, m_mosi, m_num_byte;
    logic [6:0]  m_addr;
    logic [15:0] m_divider;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];
    logic [7:0] mosi_seen[$];
    logic [7:0] slave_q[$];

    always #5 clk = ~clk;

    i2c_cmd_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cfg_divider   (cfg_divider),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_rw        (cmd_rw),
        .i_cmd_addr      (cmd_addr),
        .i_cmd_len       (cmd_len),
        .i_wr_valid      (wr_valid),
        .i_wr_data       (wr_data),
        .o_wr_ready      (wr_ready),
        .o_rd_valid      (rd_valid),
        .o_rd_data       (rd_data),
        .i_rd_ready      (rd_ready),
        .o_done          (done),
        .o_err           (err),
        .o_m_enable      (m_enable),
        .o_m_rw          (m_rw),
        .o_m_mosi_data   (m_mosi),
        .o_m_device_addr (m_addr),
        .o_m_num_byte    (m_num_byte),
        .o_m_divider     (m_divider),
        .i_m_en_ack      (m_en_ack),
        .i_m_data_valid  (m_data_valid),
        .i_m_miso_data   (m_miso),
        .i_m_busy        (m_busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gap();
        return int'($urandom_range(2, 5));
    endfunction

    task automatic push_tx(input logic [7:0] b);
        int t = 0;
        while (wr_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        chk("wr_ready", wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
        tx_model.push_back(b);
    endtask

    task automatic drop_tx(input int n);
        logic [7:0] junk;
        for (int i = 0; i < n; i++) junk = tx_model.pop_front();
    endtask

    task automatic pop_rx_check(input string tag);
        logic [7:0] e;
        e = rx_model.pop_front();
        chk({tag, "_rd_valid"}, rd_valid, 1'b1);
        chk({tag, "_rd_data"}, rd_data, e);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    // Occupancy probes: write len L is ready iff TX holds >= L bytes,
    // read len L is ready iff RX has >= L free entries.
    task automatic probe_tx(input string tag, input int occ);
        cmd_valid = 1'b0;
        cmd_rw    = RW_WRITE;
        if (occ > 0) begin
            cmd_len = 8'(occ);
            #1 chk({tag, "_tx_has"}, cmd_ready, 1'b1);
        end
        if (occ < 16) begin
            cmd_len = 8'(occ + 1);
            #1 chk({tag, "_tx_lacks"}, cmd_ready, 1'b0);
        end
    endtask

    task automatic probe_rx(input string tag, input int free);
        cmd_valid = 1'b0;
        cmd_rw    = RW_READ;
        if (free > 0) begin
            cmd_len = 8'(free);
            #1 chk({tag, "_rx_room"}, cmd_ready, 1'b1);
        end
        if (free < 16) begin
            cmd_len = 8'(free + 1);
            #1 chk({tag, "_rx_noroom"}, cmd_ready, 1'b0);
        end
    endtask

    task automatic send_cmd(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] len);
        int t = 0;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        #1;
        while (cmd_ready !== 1'b1 && t < 200) begin
            step();
            #1;
            t++;
        end
        chk({tag, "_accept"}, cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic rw, input logic [6:0] addr,
                               input logic [7:0] len);
        chk({tag, "_enable"}, m_enable, 1'b1);
        chk({tag, "_rw"}, m_rw, rw);
        chk({tag, "_addr"}, m_addr, addr);
        chk({tag, "_num"}, m_num_byte, len);
    endtask

    task automatic check_done(input string tag, input logic exp_err);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_en_off"}, m_enable, 1'b0);
        step();
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    // Byte-level master model for writes: en_ack at START consumes byte 0,
    // then one en_ack per further byte; an address NACK ends the burst early.
    task automatic master_write(input string tag, input int n, input bit nack);
        mosi_seen.delete();
        m_busy = 1'b1;
        step();
        repeat (gap()) step();
        m_en_ack = 1'b1;
        mosi_seen.push_back(m_mosi);
        step();
        m_en_ack = 1'b0;
        if (!nack) begin
            for (int i = 1; i < n; i++) begin
                repeat (gap()) step();
                m_en_ack = 1'b1;
                mosi_seen.push_back(m_mosi);
                step();
                m_en_ack = 1'b0;
            end
        end
        repeat (gap()) step();
        if (!nack) chk({tag, "_en_low_at_end"}, m_enable, 1'b0);
        m_busy = 1'b0;
        step();
    endtask

    task automatic master_read(input string tag, input int n);
        m_busy = 1'b1;
        step();
        repeat (gap()) step();
        m_en_ack = 1'b1;
        step();
        m_en_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap()) step();
            m_miso = (slave_q.size() > 0) ? slave_q.pop_front() : 8'($urandom);
            rx_model.push_back(m_miso);
            m_data_valid = 1'b1;
            step();
            m_data_valid = 1'b0;
        end
        repeat (gap()) step();
        chk({tag, "_en_low_before_fall"}, m_enable, 1'b0);
        m_busy = 1'b0;
        step();
    endtask

    task automatic check_written(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_mosi"}, (mosi_seen.size() > i) ? mosi_seen[i] : 8'hxx, tx_model[i]);
        end
    endtask

    initial begin
        logic       rw;
        logic [6:0] addr;
        int         n;
        bit         nack;

        // Reset values
        step();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_m_enable", m_enable, 1'b0);
        chk("rst_m_rw", m_rw, 1'b0);
        chk("rst_m_mosi", m_mosi, 8'h00);
        chk("rst_m_addr", m_addr, 7'h00);
        chk("rst_m_num", m_num_byte, 8'h00);
        chk("divider_pass", m_divider, DEFAULT_DIVIDER);
        rst_n = 1'b1;
        step();
        chk("post_rst_wr_ready", wr_ready, 1'b1);
        cmd_len = 8'd0;
        #1 chk("rst_wait_hold", cmd_ready, 1'b0);
        step();
        cmd_len = 8'd0;
        #1 chk("rst_wait_exit", cmd_ready, 1'b1);
        probe_tx("init", 0);
        probe_rx("init", 16);

        // 3-byte write
        push_tx(8'hA5);
        push_tx(8'h3C);
        push_tx(8'h0F);
        probe_tx("wr3_pre", 3);
        send_cmd("wr3", RW_WRITE, 7'h50, 8'd3);
        check_issue("wr3", RW_WRITE, 7'h50, 8'd3);
        master_write("wr3", 3, 1'b0);
        check_written("wr3", 3);
        drop_tx(3);
        check_done("wr3", 1'b0);
        probe_tx("wr3_post", 0);

        // 2-byte read
        slave_q.push_back(8'h12);
        slave_q.push_back(8'h34);
        send_cmd("rd2", RW_READ, 7'h68, 8'd2);
        check_issue("rd2", RW_READ, 7'h68, 8'd2);
        master_read("rd2", 2);
        check_done("rd2", 1'b0);
        chk("rd2_head", rd_data, 8'h12);
        pop_rx_check("rd2_0");
        pop_rx_check("rd2_1");
        chk("rd2_empty", rd_valid, 1'b0);

        // Address NACK on a 2-byte write
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        send_cmd("nack", RW_WRITE, 7'h33, 8'd2);
        master_write("nack", 2, 1'b1);
        check_written("nack", 1);
        drop_tx(2);
        check_done("nack", 1'b1);
        probe_tx("nack_flushed", 0);

        // Illegal lengths
        send_cmd("len0", RW_WRITE, 7'h11, 8'd0);
        check_done("len0", 1'b1);
        send_cmd("len17", RW_READ, 7'h11, 8'd17);
        check_done("len17", 1'b1);
        step();
        chk("illegal_no_enable", m_enable, 1'b0);

        // Ready gating: write len 4 with 3 buffered
        for (int i = 0; i < 3; i++) push_tx(8'($urandom));
        for (int i = 0; i < 3; i++) begin
            cmd_rw  = RW_WRITE;
            cmd_len = 8'd4;
            #1 chk("gate_wr_hold", cmd_ready, 1'b0);
            step();
        end
        push_tx(8'($urandom));
        send_cmd("gate_wr", RW_WRITE, 7'h21, 8'd4);
        master_write("gate_wr", 4, 1'b0);
        check_written("gate_wr", 4);
        drop_tx(4);
        check_done("gate_wr", 1'b0);
        probe_tx("gate_wr_post", 0);

        // Ready gating: read len 16 with one unread RX byte
        send_cmd("gate_rd1", RW_READ, 7'h44, 8'd1);
        master_read("gate_rd1", 1);
        check_done("gate_rd1", 1'b0);
        probe_rx("gate_rd_hold", 15);
        pop_rx_check("gate_rd_pop");
        probe_rx("gate_rd_free", 16);
        send_cmd("gate_rd16", RW_READ, 7'h44, 8'd16);
        master_read("gate_rd16", 16);
        check_done("gate_rd16", 1'b0);
        probe_rx("gate_rd16_full", 0);
        for (int i = 0; i < 16; i++) pop_rx_check("gate_rd16");

        // Randomized commands
        for (int it = 0; it < 6; it++) begin
            rw   = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 16));
            addr = 7'($urandom);
            if (rw == RW_WRITE) begin
                nack = (n >= 2) && ($urandom_range(0, 3) == 0);
                for (int i = 0; i < n; i++) push_tx(8'($urandom));
                send_cmd("rnd_wr", RW_WRITE, addr, 8'(n));
                check_issue("rnd_wr", RW_WRITE, addr, 8'(n));
                master_write("rnd_wr", n, nack);
                check_written("rnd_wr", nack ? 1 : n);
                drop_tx(n);
                check_done("rnd_wr", nack);
                probe_tx("rnd_wr_post", 0);
            end else begin
                send_cmd("rnd_rd", RW_READ, addr, 8'(n));
                check_issue("rnd_rd", RW_READ, addr, 8'(n));
                master_read("rnd_rd", n);
                check_done("rnd_rd", 1'b0);
                for (int i = 0; i < n; i++) pop_rx_check("rnd_rd");
            end
        end

        // Reset during the second byte of a 4-byte write
        for (int i = 0; i < 4; i++) push_tx(8'($urandom));
        send_cmd("rstx", RW_WRITE, 7'h2A, 8'd4);
        m_busy = 1'b1;
        step();
        repeat (2) step();
        m_en_ack = 1'b1;
        step();
        m_en_ack = 1'b0;
        repeat (2) step();
        chk("rstx_enable_before", m_enable, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstx_enable", m_enable, 1'b0);
        chk("rstx_cmd_ready", cmd_ready, 1'b0);
        chk("rstx_wr_ready", wr_ready, 1'b0);
        chk("rstx_rd_valid", rd_valid, 1'b0);
        chk("rstx_mosi", m_mosi, 8'h00);
        chk("rstx_addr", m_addr, 7'h00);
        chk("rstx_num", m_num_byte, 8'h00);
        step();
        rst_n = 1'b1;
        tx_model.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            cmd_len = 8'd0;
            #1 chk("rstx_wait_busy", cmd_ready, 1'b0);
        end
        m_busy = 1'b0;
        step();
        cmd_len = 8'd0;
        #1 chk("rstx_idle_1", cmd_ready, 1'b0);
        step();
        cmd_len = 8'd0;
        #1 chk("rstx_idle_2", cmd_ready, 1'b1);
        probe_tx("rstx_tx_lost", 0);
        chk("rstx_rx_lost", rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
